// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: reset/bubble constants and
// the next-PC source selector.
package fetch_stage_pkg;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  // sll $0,$0,0
  localparam logic [31:0] NopInstr       = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_SEQ,
    PC_BRANCH,
    PC_JUMP
  } pc_sel_e;

endpackage

// File: rtl/adder.sv
// Plain combinational adder; carry-out is dropped so results wrap modulo 2^Width.
module adder #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: sync reset and clear both insert a bubble; clear wins
// over enable, and enable low holds the current contents.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  input  logic        valid_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, pc_plus4_q;
  logic        valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else if (en_i) begin
      instr_q    <= instr_i;
      pc_plus4_q <= pc_plus4_i;
      valid_q    <= valid_i;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with stall/branch/jump selection, wait-state
// tolerant instruction memory interface and the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DefaultResetPc,
  parameter logic [31:0] NOP_INSTR = NopInstr
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_f_i,
  input  logic        stall_d_i,
  input  logic        flush_d_i,
  input  logic        pc_src_d_i,
  input  logic [31:0] pc_branch_i32,
  input  logic        jump_d_i,
  output logic [31:0] imem_addr_o32,
  input  logic [31:0] imem_rdata_i32,
  input  logic        imem_ready_i,
  output logic [31:0] instr_od32,
  output logic [31:0] pc_plus4_od32,
  output logic        valid_od
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target, branch_target;
  logic        redirect;
  pc_sel_e     pc_sel;
  logic        ifid_en, ifid_clr;

  adder #(
    .Width(32)
  ) u_pc_adder (
    .a_i  (pc_q),
    .b_i  (32'd4),
    .sum_o(pc_plus4)
  );

  // Jump fields come from the instruction currently sitting in decode.
  assign jump_target   = {pc_plus4_od32[31:28], instr_od32[25:0], 2'b00};
  assign branch_target = pc_branch_i32 & 32'hFFFF_FFFC;
  assign redirect      = jump_d_i | pc_src_d_i;

  always_comb begin
    pc_sel = PC_HOLD;
    if (stall_f_i) begin
      pc_sel = PC_HOLD;
    end else if (jump_d_i) begin
      pc_sel = PC_JUMP;
    end else if (pc_src_d_i) begin
      pc_sel = PC_BRANCH;
    end else if (imem_ready_i) begin
      pc_sel = PC_SEQ;
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      PC_HOLD:   pc_d = pc_q;
      PC_SEQ:    pc_d = pc_plus4;
      PC_BRANCH: pc_d = branch_target;
      PC_JUMP:   pc_d = jump_target;
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr_o32 = pc_q;

  // Flush beats stall; otherwise a redirect or a missing word leaves a bubble.
  assign ifid_clr = flush_d_i | (~stall_d_i & (redirect | ~imem_ready_i));
  assign ifid_en  = ~stall_d_i;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (ifid_en),
    .clr_i     (ifid_clr),
    .instr_i   (imem_rdata_i32),
    .pc_plus4_i(pc_plus4),
    .valid_i   (1'b1),
    .instr_o   (instr_od32),
    .pc_plus4_o(pc_plus4_od32),
    .valid_o   (valid_od)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, wait states, branch, jump
// priority, stall/flush, reset mid wait-state and PC wrap.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_f_i, stall_d_i, flush_d_i;
  logic        pc_src_d_i, jump_d_i;
  logic [31:0] pc_branch_i32;
  logic [31:0] imem_addr_o32;
  logic [31:0] imem_rdata_i32;
  logic        imem_ready_i;
  logic [31:0] instr_od32, pc_plus4_od32;
  logic        valid_od;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_f_i     (stall_f_i),
    .stall_d_i     (stall_d_i),
    .flush_d_i     (flush_d_i),
    .pc_src_d_i    (pc_src_d_i),
    .pc_branch_i32 (pc_branch_i32),
    .jump_d_i      (jump_d_i),
    .imem_addr_o32 (imem_addr_o32),
    .imem_rdata_i32(imem_rdata_i32),
    .imem_ready_i  (imem_ready_i),
    .instr_od32    (instr_od32),
    .pc_plus4_od32 (pc_plus4_od32),
    .valid_od      (valid_od)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then compare all fetch outputs away from the edge.
  task automatic step_check(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
    @(posedge clk_i);
    #1;
    check_eq({tag, ".addr"}, imem_addr_o32, addr);
    check_eq({tag, ".instr"}, instr_od32, instr);
    check_eq({tag, ".pc4"}, pc_plus4_od32, pc4);
    check_eq({tag, ".valid"}, {31'b0, valid_od}, {31'b0, valid});
  endtask

  initial begin
    rst_i = 1'b1;
    stall_f_i = 1'b0; stall_d_i = 1'b0; flush_d_i = 1'b0;
    pc_src_d_i = 1'b0; jump_d_i = 1'b0; pc_branch_i32 = 32'h0;
    imem_ready_i = 1'b0; imem_rdata_i32 = 32'h0;

    step_check("reset", 32'h0, 32'h0, 32'h0, 1'b0);

    // Back-to-back fetch, one cycle to decode.
    rst_i = 1'b0; imem_ready_i = 1'b1; imem_rdata_i32 = 32'hA;
    step_check("seq0", 32'h4, 32'hA, 32'h4, 1'b1);
    imem_rdata_i32 = 32'hB;
    step_check("seq1", 32'h8, 32'hB, 32'h8, 1'b1);
    imem_rdata_i32 = 32'hC;
    step_check("seq2", 32'hC, 32'hC, 32'hC, 1'b1);
    imem_rdata_i32 = 32'hD;
    step_check("seq3", 32'h10, 32'hD, 32'h10, 1'b1);

    // Three wait states at 0x10.
    imem_ready_i = 1'b0; imem_rdata_i32 = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) step_check("wait", 32'h10, 32'h0, 32'h0, 1'b0);
    imem_ready_i = 1'b1; imem_rdata_i32 = 32'h1111_0010;
    step_check("wait_done", 32'h14, 32'h1111_0010, 32'h14, 1'b1);

    imem_rdata_i32 = 32'h14;
    step_check("seq4", 32'h18, 32'h14, 32'h18, 1'b1);
    imem_rdata_i32 = 32'h18;
    step_check("seq5", 32'h1C, 32'h18, 32'h1C, 1'b1);
    imem_rdata_i32 = 32'h1C;
    step_check("seq6", 32'h20, 32'h1C, 32'h20, 1'b1);

    // Taken branch at 0x20; low target bits are dropped.
    pc_src_d_i = 1'b1; pc_branch_i32 = 32'h43; imem_rdata_i32 = 32'hDEAD;
    step_check("br", 32'h40, 32'h0, 32'h0, 1'b0);
    pc_src_d_i = 1'b0; imem_rdata_i32 = 32'h4040;
    step_check("br_tgt", 32'h44, 32'h4040, 32'h44, 1'b1);

    // Move to 0x1000_0004 so decode holds the jump with pc+4 = 0x1000_0008.
    pc_src_d_i = 1'b1; pc_branch_i32 = 32'h1000_0004;
    step_check("br2", 32'h1000_0004, 32'h0, 32'h0, 1'b0);
    pc_src_d_i = 1'b0; imem_rdata_i32 = 32'h0800_0010;
    step_check("jload", 32'h1000_0008, 32'h0800_0010, 32'h1000_0008, 1'b1);

    // Jump and branch together: jump wins.
    jump_d_i = 1'b1; pc_src_d_i = 1'b1; pc_branch_i32 = 32'h80; imem_rdata_i32 = 32'hBAD0;
    step_check("jump", 32'h1000_0040, 32'h0, 32'h0, 1'b0);
    jump_d_i = 1'b0; pc_src_d_i = 1'b0; imem_rdata_i32 = 32'h5050;
    step_check("jump_tgt", 32'h1000_0044, 32'h5050, 32'h1000_0044, 1'b1);

    // Full stall holds everything; flush overrides the decode stall.
    stall_f_i = 1'b1; stall_d_i = 1'b1; imem_rdata_i32 = 32'h6060;
    for (int i = 0; i < 2; i++) step_check("stall", 32'h1000_0044, 32'h5050, 32'h1000_0044, 1'b1);
    flush_d_i = 1'b1;
    step_check("flush", 32'h1000_0044, 32'h0, 32'h0, 1'b0);
    stall_f_i = 1'b0; stall_d_i = 1'b0; flush_d_i = 1'b0; imem_rdata_i32 = 32'h7070;
    step_check("resume", 32'h1000_0048, 32'h7070, 32'h1000_0048, 1'b1);

    // Reset during a wait state at 0x30.
    pc_src_d_i = 1'b1; pc_branch_i32 = 32'h30;
    step_check("br3", 32'h30, 32'h0, 32'h0, 1'b0);
    pc_src_d_i = 1'b0; imem_ready_i = 1'b0;
    step_check("wait30", 32'h30, 32'h0, 32'h0, 1'b0);
    rst_i = 1'b1; imem_ready_i = 1'b1; imem_rdata_i32 = 32'h3030;
    step_check("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0);
    rst_i = 1'b0; imem_rdata_i32 = 32'hAAAA;
    step_check("after_rst", 32'h4, 32'hAAAA, 32'h4, 1'b1);

    // PC+4 wraps from the top of the address space.
    pc_src_d_i = 1'b1; pc_branch_i32 = 32'hFFFF_FFFC;
    step_check("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    pc_src_d_i = 1'b0; imem_rdata_i32 = 32'hBBBB;
    step_check("wrap", 32'h0, 32'hBBBB, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
